// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared forwarding encodings, PC register index and destination record
package arm_pipe_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [3:0] REG_PC = 4'd15;
  typedef struct packed {
    logic [3:0] idx;
    logic       we;
  } dest_t;
endpackage

// File: rtl/hazard_dest_track.sv
// hazard_dest_track: E->M->W destination/write-enable shift register, never stalled
module hazard_dest_track #(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] wa3e,
  input  logic             rwe,
  output logic [REG_W-1:0] wa3m,
  output logic             rwm,
  output logic [REG_W-1:0] wa3w,
  output logic             rww
);
  // shift the Execute destination down the pipe every cycle; async active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wa3m <= '0;
      rwm  <= 1'b0;
      wa3w <= '0;
      rww  <= 1'b0;
    end else begin
      wa3m <= wa3e;
      rwm  <= rwe;
      wa3w <= wa3m;
      rww  <= rwm;
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, stalls, flushes and stall counter; FORWARD_EN enables bypassing
module hazard_unit
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [REG_W-1:0] PC = REG_W'(REG_PC);
  logic [REG_W-1:0] wa3m, wa3w;
  logic rwm, rww, hazard;
  hazard_dest_track #(.REG_W(REG_W)) u_track (
    .clk (clk),
    .rst (rst),
    .wa3e(WA3E),
    .rwe (RegWriteE),
    .wa3m(wa3m),
    .rwm (rwm),
    .wa3w(wa3w),
    .rww (rww)
  );
`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] ra, input logic [REG_W-1:0] m,
                                         input logic mw, input logic [REG_W-1:0] w, input logic ww);
    return (ra == PC) ? FWD_RF : (mw && ra == m) ? FWD_M : (ww && ra == w) ? FWD_W : FWD_RF;
  endfunction
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{RA1E, RA2E, wa3w, rww, MemtoRegE};
  function automatic logic dep(input logic [REG_W-1:0] ra, input logic [REG_W-1:0] e, input logic ew,
                               input logic [REG_W-1:0] m, input logic mw);
    return (ra != PC) && ((ew && ra == e) || (mw && ra == m));
  endfunction
`endif
  // hazard detection and output resolution; branch kills the stall, reset forces everything idle
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
`ifdef FORWARD_EN
    ForwardAE = rst ? fwd_sel(RA1E, wa3m, rwm, wa3w, rww) : FWD_RF;
    ForwardBE = rst ? fwd_sel(RA2E, wa3m, rwm, wa3w, rww) : FWD_RF;
    hazard = MemtoRegE && RegWriteE && WA3E != PC && (RA1D == WA3E || RA2D == WA3E);
`else
    hazard = dep(RA1D, WA3E, RegWriteE, wa3m, rwm) || dep(RA2D, WA3E, RegWriteE, wa3m, rwm);
`endif
    StallD = rst && hazard && !BranchTakenE;
    StallF = StallD;
    FlushD = rst && BranchTakenE;
    FlushE = rst && (hazard || BranchTakenE);
  end
  // saturating count of stalled Decode cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count <= '0;
    else if (StallD && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, random model run and saturation/reset sequences for hazard_unit
module tb_hazard_unit;
  import arm_pipe_pkg::*;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E;
  logic RegWriteE, MemtoRegE, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic [15:0] stall_count;
  int tests = 0, fails = 0, exp_cnt = 0;
  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e;
    logic rwe, mtr, br;
    logic [1:0] fa, fb;
    logic st, fd, fe;
  } vec_t;
  vec_t tbl[15];
  vec_t sb[$];
  dest_t m, w;

  hazard_unit dut (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a1d, a2d, a1e, a2e, wa, rwe, mtr, br, fa, fb, st, fd, fe);
    vec_t v;
    v.ra1d = 4'(a1d); v.ra2d = 4'(a2d); v.ra1e = 4'(a1e); v.ra2e = 4'(a2e); v.wa3e = 4'(wa);
    v.rwe = 1'(rwe); v.mtr = 1'(mtr); v.br = 1'(br);
    v.fa = 2'(fa); v.fb = 2'(fb); v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe);
    return v;
  endfunction

  function automatic logic [1:0] fsel(input logic [3:0] ra);
    return (ra == 4'd15) ? 2'b00 : (m.we && ra == m.idx) ? 2'b10 : (w.we && ra == w.idx) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic dep(input logic [3:0] ra, input vec_t v);
    return ra != 4'd15 && ((v.rwe && ra == v.wa3e) || (m.we && ra == m.idx));
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    logic hz;
    hz = FWD ? (v.mtr && v.rwe && v.wa3e != 4'd15 && (v.ra1d == v.wa3e || v.ra2d == v.wa3e))
             : (dep(v.ra1d, v) || dep(v.ra2d, v));
    e.fa = FWD ? fsel(v.ra1e) : 2'b00;
    e.fb = FWD ? fsel(v.ra2e) : 2'b00;
    e.st = hz && !v.br;
    e.fd = v.br;
    e.fe = hz || v.br;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e; WA3E = v.wa3e;
    RegWriteE = v.rwe; MemtoRegE = v.mtr; BranchTakenE = v.br;
    sb.push_back(v);
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    e = sb.pop_front();
    chk({tag, ".fa"}, 32'(ForwardAE), 32'(e.fa));
    chk({tag, ".fb"}, 32'(ForwardBE), 32'(e.fb));
    chk({tag, ".stallf"}, 32'(StallF), 32'(e.st));
    chk({tag, ".stalld"}, 32'(StallD), 32'(e.st));
    chk({tag, ".flushd"}, 32'(FlushD), 32'(e.fd));
    chk({tag, ".flushe"}, 32'(FlushE), 32'(e.fe));
    chk({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
    if (e.st && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic zero_in();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0;
    RegWriteE = 0; MemtoRegE = 0; BranchTakenE = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".fa"}, 32'(ForwardAE), 0);
    chk({tag, ".fb"}, 32'(ForwardBE), 0);
    chk({tag, ".stall"}, 32'({StallF, StallD}), 0);
    chk({tag, ".flush"}, 32'({FlushD, FlushE}), 0);
    chk({tag, ".cnt"}, 32'(stall_count), 0);
  endtask

  initial begin
    vec_t v, e;
    // ra1d ra2d ra1e ra2e wa3e rwe mtr br | fa fb st fd fe
    tbl[0]  = mk(0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 3, 0, 0, 0, 0, 0,  FWD ? 2 : 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 3, 0, 0, 0, 0, 0,  FWD ? 1 : 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 5, 15, 1, 0, 0, 0, FWD ? 2 : 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 15, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(2, 0, 0, 0, 2, 1, 1, 0,  0, 0, 1, 0, 1);
    tbl[8]  = mk(2, 0, 0, 0, 0, 0, 0, 0,  0, 0, FWD ? 0 : 1, 0, FWD ? 0 : 1);
    tbl[9]  = mk(2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[10] = mk(0, 6, 0, 0, 6, 1, 1, 1,  0, 0, 0, 1, 1);
    tbl[11] = mk(15, 0, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(4, 0, 0, 0, 4, 1, 0, 0,  0, 0, FWD ? 0 : 1, 0, FWD ? 0 : 1);
    tbl[13] = mk(4, 0, 0, 0, 0, 0, 0, 0,  0, 0, FWD ? 0 : 1, 0, FWD ? 0 : 1);
    tbl[14] = mk(4, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    RA1D = 2; RA2D = 2; RA1E = 0; RA2E = 0; WA3E = 2;
    RegWriteE = 1; MemtoRegE = 1; BranchTakenE = 1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    zero_in();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check_out($sformatf("v%0d", i));
    end

    @(negedge clk);
    zero_in();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    m = '0;
    w = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.ra1d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.ra2d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.ra1e = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.ra2e = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.wa3e = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.rwe = $urandom_range(0, 2) != 0;
      v.mtr = $urandom_range(0, 1) == 1;
      v.br = $urandom_range(0, 5) == 0;
      e = model(v);
      drive(e);
      #1 check_out("rnd");
      @(posedge clk);
      w = m;
      m.idx = v.wa3e;
      m.we = v.rwe;
    end

    @(negedge clk);
    RA1D = 2; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 2;
    RegWriteE = 1; MemtoRegE = 1; BranchTakenE = 0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat.cnt", 32'(stall_count), 32'hFFFF);
    chk("sat.stalld", 32'(StallD), 1);
    #2 rst = 1'b0;
    #1 chk_idle("midrst");
    @(posedge clk);
    #1 chk("midrst.hold", 32'(stall_count), 0);
    @(negedge clk);
    zero_in();
    RA1D = 2; RA1E = 2; RA2E = 2;
    rst = 1'b1;
    #1 chk_idle("post");
    @(negedge clk);
    RA1D = 0; RA1E = 0; RA2E = 0; RA2D = 7; WA3E = 7;
    RegWriteE = 1; MemtoRegE = 1;
    #1 chk("one.stalld", 32'(StallD), 1);
    @(negedge clk);
    zero_in();
    chk("one.cnt", 32'(stall_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
